// File: rtl/aes_block_stitcher.sv
// aes_block_stitcher
// Collects processed AES blocks, which may arrive out of order and are tagged
// with their block index, and reassembles them into one message word. The
// message is then offered on a valid/ready handshake. Once a message is
// complete, no new block is taken until the consumer accepts that message.
module aes_block_stitcher #(
    parameter int BLOCK_W    = 128,
    parameter int NUM_BLOCKS = 32,
    parameter int IDX_W      = 5,
    parameter int MSG_W      = BLOCK_W * NUM_BLOCKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSG_W-1:0]   out_data,
    output logic               dup_err,
    output logic [IDX_W:0]     blk_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                state;
    logic [NUM_BLOCKS-1:0] present;
    logic                  accept;
    logic                  is_new;
    logic                  last_block;

    // in_ready is only ever high in COLLECT. The state term makes that
    // explicit rather than relying on it.
    assign accept     = in_valid && in_ready && (state == COLLECT);
    assign is_new     = accept && !present[in_idx];
    assign last_block = is_new && (blk_count == (IDX_W+1)'(NUM_BLOCKS - 1));

    // Control FSM. The handshake outputs are registered so that they depend
    // only on state and never on in_valid or out_ready in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            dup_err   <= 1'b0;
            blk_count <= '0;
            present   <= '0;
        end else begin
            // A block whose slot is already filled is dropped and flagged
            // for exactly one cycle.
            dup_err <= accept && present[in_idx];
            case (state)
                COLLECT: begin
                    if (is_new) begin
                        present[in_idx] <= 1'b1;
                        blk_count       <= blk_count + (IDX_W+1)'(1);
                    end
                    if (last_block) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                HOLD: begin
                    // No bypass: a block presented in this cycle is not
                    // accepted, because in_ready is low throughout HOLD.
                    if (out_ready) begin
                        state     <= COLLECT;
                        present   <= '0;
                        blk_count <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // Slot storage. After a handshake, each slot keeps the old data until a
    // new block for that index overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (is_new) begin
            out_data[in_idx*BLOCK_W +: BLOCK_W] <= in_data;
        end
    end

endmodule

// File: tb/tb_aes_block_stitcher.sv
// tb_aes_block_stitcher
// A reference model that tracks the set of received slots is compared
// against the DUT outputs on every cycle. The directed scenarios also check
// hand-computed literal values, and a randomized phase follows them.
module tb_aes_block_stitcher;

    localparam int BLOCK_W    = 128;
    localparam int NUM_BLOCKS = 32;
    localparam int IDX_W      = 5;
    localparam int MSG_W      = BLOCK_W * NUM_BLOCKS;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IDX_W-1:0]   in_idx = '0;
    logic [BLOCK_W-1:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [MSG_W-1:0]   out_data;
    logic               dup_err;
    logic [IDX_W:0]     blk_count;

    aes_block_stitcher #(
        .BLOCK_W(BLOCK_W), .NUM_BLOCKS(NUM_BLOCKS), .IDX_W(IDX_W), .MSG_W(MSG_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .dup_err(dup_err),
        .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the set of slots received, their contents, and
    // whether a finished message is waiting for the consumer.
    logic [BLOCK_W-1:0]    m_slot [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] m_have;
    bit                    m_full, m_rdy, m_dup;

    always @(posedge clk) begin
        if (rst) begin
            m_have = '0; m_full = 0; m_rdy = 0; m_dup = 0;
            for (int k = 0; k < NUM_BLOCKS; k++) m_slot[k] = '0;
        end else begin
            m_dup = 0;
            if (m_full) begin
                if (out_ready) begin
                    m_full = 0; m_have = '0; m_rdy = 1;
                end
            end else if (m_rdy && in_valid) begin
                if (m_have[in_idx]) m_dup = 1;
                else begin
                    m_slot[in_idx] = in_data;
                    m_have[in_idx] = 1'b1;
                end
                if (&m_have) begin
                    m_full = 1; m_rdy = 0;
                end
            end else begin
                m_rdy = 1;
            end
        end
    end

    function automatic logic [MSG_W-1:0] model_msg();
        logic [MSG_W-1:0] m;
        for (int k = 0; k < NUM_BLOCKS; k++) m[k*BLOCK_W +: BLOCK_W] = m_slot[k];
        return m;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_msg(input string nm, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (act[k*BLOCK_W +: BLOCK_W] !== exp[k*BLOCK_W +: BLOCK_W]) begin
                    $display("FAIL %s: slot %0d got %0h expected %0h (cycle %0d)", nm, k,
                             act[k*BLOCK_W +: BLOCK_W], exp[k*BLOCK_W +: BLOCK_W], cyc);
                    break;
                end
            end
        end
    endtask

    // Compare process. It runs on the falling edge, when all DUT outputs
    // are stable.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, m_full);
            chk("dup_err", dup_err, m_dup);
            chk("blk_count", blk_count, $countones(m_have));
            if (m_full) chk_msg("out_data", out_data, model_msg());
        end
    end

    // Called on a falling edge. It presents a block, waits for in_ready, and
    // returns on the falling edge just after the accepting rising edge.
    task automatic send(input logic [IDX_W-1:0] idx, input logic [BLOCK_W-1:0] d);
        int guard = 0;
        in_valid = 1'b1; in_idx = idx; in_data = d;
        while (!in_ready && guard < 200) begin
            @(negedge clk); guard++;
        end
        if (guard >= 200) begin
            vectors++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for idx %0d", idx);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [MSG_W-1:0]   exp_msg;
    logic [MSG_W-1:0]   snap;
    logic [BLOCK_W-1:0] keep3;
    int t0, t1;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_dup_err", dup_err, 0);
        chk_msg("rst_out_data", out_data, '0);
        @(negedge clk);
        chk("rst_in_ready_rise", in_ready, 1);

        // Send the blocks in order, with out_ready already high.
        out_ready = 1'b1;
        for (int i = 0; i < NUM_BLOCKS; i++) send(IDX_W'(i), {4{32'(i)}});
        chk("t1_latency", out_valid, 1);
        for (int k = 0; k < NUM_BLOCKS; k++) exp_msg[k*BLOCK_W +: BLOCK_W] = {4{32'(k)}};
        chk_msg("t1_msg", out_data, exp_msg);
        @(negedge clk);
        chk("t1_vld_drop", out_valid, 0);
        chk("t1_rdy_back", in_ready, 1);

        // Send the blocks in reverse order, all ones.
        out_ready = 1'b0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) send(IDX_W'(i), {BLOCK_W{1'b1}});
        chk("t2_count", blk_count, 32);
        chk_msg("t2_msg", out_data, {MSG_W{1'b1}});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t2_vld_drop", out_valid, 0);

        // Duplicate index
        for (int i = 0; i < 5; i++) send(IDX_W'(i), {4{32'hA000_0000 + 32'(i)}});
        keep3 = {4{32'hA000_0003}};
        send(5'd3, 128'hDEAD);
        chk("t3_dup_pulse", dup_err, 1);
        chk("t3_dup_count", blk_count, 5);
        @(negedge clk);
        chk("t3_dup_end", dup_err, 0);
        for (int i = 5; i < NUM_BLOCKS; i++) send(IDX_W'(i), {4{32'hA000_0000 + 32'(i)}});
        chk("t3_slot3", out_data[3*BLOCK_W +: BLOCK_W], keep3);

        // Hold the message under backpressure, with in_valid held high.
        snap = out_data;
        in_valid = 1'b1; in_idx = 5'd7; in_data = '1;
        repeat (10) begin
            @(negedge clk);
            chk("t4_in_ready", in_ready, 0);
            chk_msg("t4_stable", out_data, snap);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_vld_drop", out_valid, 0);
        chk("t4_rdy_back", in_ready, 1);

        // Reset in the middle of a message
        for (int i = 0; i < 17; i++) send(IDX_W'(i), {$urandom, $urandom, $urandom, $urandom});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_count", blk_count, 0);
        @(negedge clk);
        chk("t5_rdy", in_ready, 1);
        for (int i = 0; i < NUM_BLOCKS; i++) send(IDX_W'(i), {16{8'h55}});
        chk_msg("t5_msg", out_data, {512{8'h55}});

        // Throughput with out_ready tied high
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_BLOCKS; i++) send(IDX_W'(i), {4{$urandom}});
        t0 = cyc;
        chk("t6_first_vld", out_valid, 1);
        for (int i = 0; i < NUM_BLOCKS; i++) send(IDX_W'(NUM_BLOCKS - 1 - i), {4{$urandom}});
        t1 = cyc;
        chk("t6_second_vld", out_valid, 1);
        chk("t6_period", t1 - t0, 33);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 3) != 0;
            in_idx    = IDX_W'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
